// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the handshaked 8N1 UART PHY.
// Provides the frame width, FSM state encodings and baud divider math.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_ACK
  } tx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Baud counters only ever reach DIV-1, so clog2(DIV) bits are enough.
  function automatic int unsigned calc_cnt_w(input int unsigned clk_freq,
                                             input int unsigned baud);
    int unsigned div;
    div = clk_freq / baud;
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage single-bit synchroniser with a parameterised reset value.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_hs_phy.sv
// 8N1 UART PHY with four-phase req/ack handshakes on receive and transmit.
// RX and TX run independent FSMs, each with its own baud counter.
module uart_hs_phy
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  output logic                 rec_req,
  input  logic                 rec_ack,
  output logic [DATA_BITS-1:0] rec_data,
  input  logic                 send_req,
  input  logic [DATA_BITS-1:0] send_data,
  output logic                 send_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = calc_cnt_w(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic rxd_s;
  logic send_req_s;
  logic rec_ack_s;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync_rxd (
    .clk  (clk),
    .reset(reset),
    .d_i  (uart_rxd),
    .q_o  (rxd_s)
  );

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync_send_req (
    .clk  (clk),
    .reset(reset),
    .d_i  (send_req),
    .q_o  (send_req_s)
  );

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sync_rec_ack (
    .clk  (clk),
    .reset(reset),
    .d_i  (rec_ack),
    .q_o  (rec_ack_s)
  );

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rxd_prev_q;
  logic                 rec_req_q, rec_req_d;
  logic [DATA_BITS-1:0] rec_data_q, rec_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_ONE;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rec_req_d   = rec_req_q;
    rec_data_d  = rec_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rec_ack_s) begin
      rec_req_d = 1'b0;
    end

    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_s) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start-bit recheck filters short glitches.
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + IDX_ONE;
          if (rx_idx_q == IDX_LAST) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rxd_s) begin
            frame_err_d = 1'b1;
          end else if (!rec_req_q && !rec_ack_s) begin
            rec_req_d  = 1'b1;
            rec_data_d = rx_shift_q;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rxd_prev_q  <= 1'b1;
      rec_req_q   <= 1'b0;
      rec_data_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rxd_prev_q  <= rxd_s;
      rec_req_q   <= rec_req_d;
      rec_data_q  <= rec_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rec_req   = rec_req_q;
  assign rec_data  = rec_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 send_ack_q, send_ack_d;
  logic                 txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    send_ack_d = send_ack_q;

    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (send_req_s && !send_ack_q) begin
          tx_shift_d = send_data;
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + IDX_ONE;
          if (tx_idx_q == IDX_LAST) begin
            tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          send_ack_d = 1'b1;
          tx_state_d = TX_ACK;
        end
      end
      TX_ACK: begin
        tx_cnt_d = '0;
        if (!send_req_s) begin
          send_ack_d = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level follows the state being entered so txd is a clean flop output.
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      send_ack_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      send_ack_q <= send_ack_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd = txd_q;
  assign send_ack = send_ack_q;

endmodule

// File: tb/tb_uart_hs_phy.sv
// Scoreboard bench for uart_hs_phy: random bytes on both directions, checked
// against queued expectations by independent line and handshake monitors.
module tb_uart_hs_phy;

  localparam int unsigned CLK_FREQ = 5000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned SYNC     = 2;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;  // 43 cycles per bit

  logic       clk;
  logic       reset;
  logic       uart_rxd;
  logic       uart_txd;
  logic       rec_req;
  logic       rec_ack;
  logic [7:0] rec_data;
  logic       send_req;
  logic [7:0] send_data;
  logic       send_ack;
  logic       frame_err;
  logic       overrun;

  uart_hs_phy #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .rec_req  (rec_req),
    .rec_ack  (rec_ack),
    .rec_data (rec_data),
    .send_req (send_req),
    .send_data(send_data),
    .send_ack (send_ack),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         fe_cnt;
  int         ov_cnt;
  int         exp_fe;
  int         exp_ov;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  bit         hold_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse counters: a stuck-high pulse inflates the count.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    end
  end

  // TX line monitor: whole frame shape, decoded byte and ack timing.
  initial begin : tx_mon
    logic [9:0] cur;
    logic [7:0] b;
    logic [7:0] got;
    int         j;
    int         w;
    int         k;
    bit         err;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || uart_txd !== 1'b0) continue;
      if (tx_exp.size() == 0) begin
        chk("tx_unexpected_frame", 32'(1), 32'(0));
        repeat (10 * DIV) @(negedge clk);
        continue;
      end
      b       = tx_exp.pop_front();
      cur     = {1'b1, b, 1'b0};
      got     = '0;
      err     = 1'b0;
      aborted = 1'b0;
      j       = 0;
      w       = 0;
      k       = 0;
      while (j < 10 * DIV) begin
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (uart_txd !== cur[0] || send_ack !== 1'b0) err = 1'b1;
        if (w == DIV / 2 && k >= 1 && k <= 8) got = {uart_txd, got[7:1]};
        j++;
        w++;
        if (w == DIV) begin
          w   = 0;
          k++;
          cur = cur >> 1;
        end
        @(negedge clk);
      end
      if (!aborted) begin
        chk("tx_byte", 32'(got), 32'(b));
        chk("tx_line_shape", 32'(err), 32'(0));
        chk("tx_ack_at_10div", 32'(send_ack), 32'(1));
      end
    end
  end

  // RX consumer: pops expectation on each posted byte, then runs the handshake.
  initial begin : rx_mon
    int n;
    rec_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || rec_req !== 1'b1) continue;
      if (rx_exp.size() == 0) chk("rx_unexpected_byte", 32'(rec_data), 32'hFFFF_FFFF);
      else chk("rx_data", 32'(rec_data), 32'(rx_exp.pop_front()));
      n = 0;
      while (hold_ack && n < 200 * DIV) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      rec_ack = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rec_req !== 1'b0 && n < 50);
      chk("rx_req_drop_latency", 32'(n), 32'(SYNC + 1));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      rec_ack = 1'b0;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[0];
      bits     = bits >> 1;
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic rx_glitch(input int len);
    uart_rxd = 1'b0;
    repeat (len) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    chk("glitch_no_req", 32'(rec_req), 32'(0));
  endtask

  task automatic wait_rx_drained();
    int n;
    n = 0;
    while ((rx_exp.size() != 0 || rec_req !== 1'b0 || rec_ack !== 1'b0) && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk("rx_drained", 32'(rx_exp.size()), 32'(0));
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic tx_send(input logic [7:0] b, input bit drop_early);
    int n;
    n = 0;
    while (send_ack !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tx_exp.push_back(b);
    send_data = b;
    send_req  = 1'b1;
    if (drop_early) begin
      repeat (3 * DIV) @(negedge clk);
      send_req  = 1'b0;
      send_data = 8'($urandom);
    end else begin
      repeat (SYNC + 3) @(negedge clk);
      send_data = ~b;
    end
    n = 0;
    while (send_ack !== 1'b1 && n < 12 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ack_rise", 32'(send_ack), 32'(1));
    if (drop_early) begin
      @(negedge clk);
      chk("tx_ack_fall_after_drop", 32'(send_ack), 32'(0));
    end else begin
      send_req = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (send_ack !== 1'b0 && n < 20);
      chk("tx_ack_fall_latency", 32'(n), 32'(SYNC + 1));
    end
  endtask

  task automatic duplex(input logic [7:0] tb_byte, input logic [7:0] rb_byte);
    fork
      tx_send(tb_byte, 1'b0);
      begin
        repeat ($urandom_range(0, DIV)) @(negedge clk);
        rx_exp.push_back(rb_byte);
        rx_frame(rb_byte, 1'b1);
      end
    join
    wait_rx_drained();
  endtask

  initial begin : main
    total     = 0;
    bad       = 0;
    fe_cnt    = 0;
    ov_cnt    = 0;
    exp_fe    = 0;
    exp_ov    = 0;
    hold_ack  = 1'b0;
    reset     = 1'b1;
    uart_rxd  = 1'b1;
    send_req  = 1'b0;
    send_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(uart_txd), 32'(1));
    chk("reset_rec_req", 32'(rec_req), 32'(0));
    chk("reset_rec_data", 32'(rec_data), 32'(0));
    chk("reset_send_ack", 32'(send_ack), 32'(0));
    chk("reset_frame_err", 32'(frame_err), 32'(0));
    chk("reset_overrun", 32'(overrun), 32'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    tx_send(8'hA5, 1'b0);

    rx_exp.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    wait_rx_drained();

    rx_glitch(10);

    rx_frame(8'h55, 1'b0);
    exp_fe++;
    repeat (DIV) @(negedge clk);
    chk("frame_err_count", 32'(fe_cnt), 32'(exp_fe));
    chk("frame_err_no_req", 32'(rec_req), 32'(0));

    hold_ack = 1'b1;
    rx_exp.push_back(8'h11);
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    exp_ov++;
    repeat (DIV) @(negedge clk);
    chk("overrun_count", 32'(ov_cnt), 32'(exp_ov));
    chk("overrun_keeps_data", 32'(rec_data), 32'h11);
    chk("overrun_req_held", 32'(rec_req), 32'(1));
    hold_ack = 1'b0;
    wait_rx_drained();
    rx_exp.push_back(8'h33);
    rx_frame(8'h33, 1'b1);
    wait_rx_drained();

    tx_send(8'($urandom), 1'b1);

    duplex(8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) duplex(8'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) rx_glitch(int'($urandom_range(1, DIV / 4)));

    // Reset in the middle of a TX frame.
    tx_exp.push_back(8'h5A);
    send_data = 8'h5A;
    send_req  = 1'b1;
    repeat (SYNC + 1 + 3 * DIV + $urandom_range(0, DIV)) @(negedge clk);
    reset    = 1'b1;
    send_req = 1'b0;
    @(negedge clk);
    chk("midframe_reset_txd", 32'(uart_txd), 32'(1));
    chk("midframe_reset_ack", 32'(send_ack), 32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    tx_send(8'hC3, 1'b0);
    repeat (SYNC + 2) @(negedge clk);

    chk("final_frame_err_count", 32'(fe_cnt), 32'(exp_fe));
    chk("final_overrun_count", 32'(ov_cnt), 32'(exp_ov));
    chk("final_tx_queue_empty", 32'(tx_exp.size()), 32'(0));
    chk("final_rx_queue_empty", 32'(rx_exp.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_hs_phy.md
Name: uart_hs_phy

Overview:
- Serial 8N1 UART PHY with four-phase req/ack handshakes on both the receive side and the transmit side.
- Sits directly downstream of the Avalon UART slave. The slave drives send_req/send_data and rec_ack. This block drives the pins and returns rec_req/rec_data and send_ack.
- Handshake inputs may come from another clock domain, so they are resynchronised internally.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, line rate in bits/s; DIV = CLK_FREQ/BAUD (integer, truncated; 434 at defaults)
SYNC_STAGES, 2, flop stages on uart_rxd, send_req and rec_ack (minimum 2)

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
uart_rxd  in  1  serial input, idle high, asynchronous
uart_txd  out  1  serial output, idle high
rec_req  out  1  high = rec_data holds a new byte
rec_ack  in  1  consumer acknowledge (asynchronous)
rec_data  out  8  received byte, stable while rec_req=1
send_req  in  1  producer request (asynchronous)
send_data  in  8  byte to send, stable while send_req=1
send_ack  out  1  high = byte fully transmitted
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: byte dropped because the rec handshake was still busy

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high.
- Reset values: uart_txd=1, rec_req=0, rec_data=0, send_ack=0, frame_err=0, overrun=0. Both FSMs return to IDLE.
- Reset mid-frame aborts immediately. uart_txd returns high on the cycle after reset is sampled.
- Synchronisers: uart_rxd, send_req and rec_ack each pass through SYNC_STAGES flops; the FSMs use only the synchronised copies. Synchronisers reset to 1 / 0 / 0 respectively.
- Bit timing: each FSM has its own baud counter, width clog2(DIV). The counter reloads at every state entry.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synced rxd falling edge starts counting; go to START.
  - START: at count DIV/2, resample. If rxd is still low, go to DATA with count=0. If high (glitch), return to IDLE with no output.
  - DATA: sample at each DIV count (bit centre), LSB first, 8 bits; 3-bit index wraps 7 -> STOP.
  - STOP: sample at DIV.
    - Sample low: pulse frame_err and discard the byte.
    - Sample high and rx handshake free (rec_req=0 and synced rec_ack=0): load rec_data and set rec_req on the next cycle.
    - Sample high and handshake busy: pulse overrun and keep the previous rec_data unchanged.
    - Then return to IDLE. From stop-sample to IDLE takes 1 cycle; a new start bit may be detected immediately after.
- RX handshake:
  - rec_req clears on the first cycle synced rec_ack=1.
  - The next byte may not be posted until synced rec_ack=0.
- TX FSM (IDLE, START, DATA, STOP, ACK):
  - IDLE: when synced send_req=1 and send_ack=0, latch send_data into a shift register; go to START.
  - START drives 0 for DIV cycles; DATA drives 8 bits LSB first, DIV cycles each; STOP drives 1 for DIV cycles.
  - At the end of STOP: set send_ack=1 and go to ACK.
  - ACK: hold send_ack=1 (uart_txd=1) until synced send_req=0, then clear send_ack and go to IDLE.
  - A new frame cannot start until send_ack is low.
- TX timing: frame length is 10*DIV cycles. uart_txd changes at most once per DIV cycles within a frame.
- TX stability: send_req dropping mid-frame is ignored; the frame completes and ack is still raised. send_data changes after the latch have no effect.
- Independence: RX and TX are fully independent. Simultaneous rx frame end and tx request are both serviced with no interaction.

Decomposition:
- Shared package uart_pkg:
  - constant DATA_BITS=8;
  - RX state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP};
  - TX state enum {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_ACK};
  - function computing DIV and counter width from CLK_FREQ/BAUD.
- One sub-module: uart_sync (parameterised N-stage, reset-value-parameterised bit synchroniser), instantiated three times.
- RX and TX FSMs stay in the top file.

Test Plan:
- TX basic: send_req=1 with 0xA5, hold until ack. uart_txd must show 0,1,0,1,0,0,1,0,1,1, each bit 434 cycles. send_ack rises after cycle 10*434 (+sync latency). send_ack falls SYNC_STAGES+1 cycles after send_req drops.
- RX basic: drive 0x3C on uart_rxd at 115200, then ack. rec_req rises with rec_data=0x3C. rec_req drops after rec_ack is seen. No frame_err/overrun.
- RX glitch and framing: a 100-cycle low pulse on rxd produces no rec_req. Frame 0x55 with stop bit low produces a frame_err pulse and rec_req stays 0.
- RX overrun: send 0x11, never ack, send 0x22. Overrun pulses once, rec_data stays 0x11. After the full handshake, the next byte 0x33 is delivered.
- Full duplex with reset: TX 0xFF and RX 0x00 concurrently, both correct. Assert reset mid-TX-frame: uart_txd goes high the next cycle, send_ack=0, and a fresh request afterwards transmits correctly.
